// File: rtl/hc138_pkg.sv
// Shared types and constants for the 74HC138 chip-select arbiter.
// Enable polarities follow the decoder pins: E1/E2 active low, E3 active high.
package hc138_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    GRANT   = 2'd2,
    HOLDOFF = 2'd3
  } state_t;

  localparam logic E1_OFF = 1'b1;
  localparam logic E1_ON  = 1'b0;
  localparam logic E2_ON  = 1'b0;
  localparam logic E3_ON  = 1'b1;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

endpackage

// File: rtl/rr_pick8.sv
// Round-robin pick among 8 requesters: the search starts just after 'last'.
// Rotate so req[last+1] lands at bit 0, then take the lowest set bit.
module rr_pick8
  import hc138_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last,
  output logic             any,
  output logic [SEL_W-1:0] winner
);

  logic [2*N_REQ-1:0] w_dbl;
  logic [N_REQ-1:0]   w_rot;
  logic [3:0]         w_shift;
  logic [SEL_W-1:0]   w_off;

  assign w_shift = {1'b0, last} + 4'd1;
  assign w_dbl   = {req, req};
  assign w_rot   = w_dbl[w_shift +: N_REQ];

  // Scan high to low so the lowest set bit is the final assignment.
  always_comb begin
    w_off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = SEL_W'(i);
    end
  end

  assign any    = |req;
  assign winner = last + 3'd1 + w_off;

endmodule

// File: rtl/hc138_cs_arbiter.sv
// Shares one 3-to-8 decoder between 8 masters; the select is held with the decoder
// disabled for GUARD_CYC cycles on both sides of every enable window.
module hc138_cs_arbiter
  import hc138_pkg::*;
#(
  parameter int GUARD_CYC = 1,
  parameter int MAX_HOLD  = 16,
  parameter int HOLD_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  output logic [SEL_W-1:0] sel,
  output logic             e1,
  output logic             e2,
  output logic             e3,
  output logic             gnt_valid,
  output logic             timeout,
  output logic [1:0]       dbg_state
);

  localparam int GUARD_W = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;

  state_t             r_state, w_state_nxt;
  logic [SEL_W-1:0]   r_sel, w_sel_nxt;
  logic [SEL_W-1:0]   r_last, w_last_nxt;
  logic               r_e1, w_e1_nxt;
  logic               r_gnt, w_gnt_nxt;
  logic               r_timeout, w_timeout_nxt;
  logic [GUARD_W-1:0] r_guard, w_guard_nxt;
  logic [HOLD_W-1:0]  r_hold, w_hold_nxt;

  logic               w_any;
  logic [SEL_W-1:0]   w_winner;
  logic               w_done_sel;
  logic               w_req_sel;
  logic               w_limit;
  logic               w_guard_end;

  rr_pick8 u_pick (
    .req    (req),
    .last   (r_last),
    .any    (w_any),
    .winner (w_winner)
  );

  assign w_done_sel  = done[r_sel];
  assign w_req_sel   = req[r_sel];
  assign w_limit     = (r_hold == HOLD_W'(MAX_HOLD - 1));
  assign w_guard_end = (r_guard == GUARD_W'(GUARD_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_sel     <= '0;
      r_last    <= 3'd7;
      r_e1      <= E1_OFF;
      r_gnt     <= 1'b0;
      r_timeout <= 1'b0;
      r_guard   <= '0;
      r_hold    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_sel     <= w_sel_nxt;
      r_last    <= w_last_nxt;
      r_e1      <= w_e1_nxt;
      r_gnt     <= w_gnt_nxt;
      r_timeout <= w_timeout_nxt;
      r_guard   <= w_guard_nxt;
      r_hold    <= w_hold_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_sel_nxt     = r_sel;
    w_last_nxt    = r_last;
    w_e1_nxt      = r_e1;
    w_gnt_nxt     = r_gnt;
    w_timeout_nxt = 1'b0;
    w_guard_nxt   = r_guard;
    w_hold_nxt    = r_hold;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_sel_nxt   = w_winner;
          w_state_nxt = SETUP;
          w_guard_nxt = '0;
        end
      end
      SETUP: begin
        if (w_guard_end) begin
          w_state_nxt = GRANT;
          w_e1_nxt    = E1_ON;
          w_gnt_nxt   = 1'b1;
          w_hold_nxt  = '0;
        end else begin
          w_guard_nxt = r_guard + 1'b1;
        end
      end
      GRANT: begin
        w_hold_nxt = r_hold + 1'b1;
        if (w_done_sel || !w_req_sel || w_limit) begin
          w_state_nxt   = HOLDOFF;
          w_e1_nxt      = E1_OFF;
          w_gnt_nxt     = 1'b0;
          w_guard_nxt   = '0;
          // A voluntary release on the same edge as the limit is not a timeout.
          w_timeout_nxt = w_limit && !w_done_sel && w_req_sel;
        end
      end
      HOLDOFF: begin
        if (w_guard_end) begin
          w_state_nxt = IDLE;
          w_last_nxt  = r_sel;
        end else begin
          w_guard_nxt = r_guard + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign sel       = r_sel;
  assign e1        = r_e1;
  assign e2        = E2_ON;
  assign e3        = E3_ON;
  assign gnt_valid = r_gnt;
  assign timeout   = r_timeout;
  assign dbg_state = r_state;

  a_sel_stable_while_enabled : assert property (
    @(posedge clk) disable iff (rst) (r_e1 == E1_ON) |=> $stable(r_sel)
  );

endmodule
